mem_ctrl: RTL and testbench

Memory controller between the core's two memory requesters and the single byte-wide RAM/IO port. Serves the instruction fetcher (32-bit reads) and the load/store buffer (byte/half/word loads and stores, signed or unsigned) one request at a time. Splits each access into byte beats, assembles or extends the result, and returns a one-cycle ready pulse to the owner.

---
 rtl/mem_ctrl_if.sv | 41 ++++
 rtl/mem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response and RAM-port bundle for the memory controller.
//   clear / io_buffer_full : flush from the ROB, UART buffer full
//   mem_*                  : byte-wide RAM/IO port
//   inst_*                 : instruction-fetch channel (32-bit reads)
//   data_*                 : load/store-buffer channel
// Modport slave is the controller's view; master is the requesters + RAM side.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              clear;
  logic              io_buffer_full;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              inst_valid;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ready;
  logic [31:0]       inst_res;
  logic              data_valid;
  logic              data_wr;
  logic [2:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_value;
  logic              data_ready;
  logic [31:0]       data_res;

  modport slave (
    input  clear, io_buffer_full, mem_din,
           inst_valid, inst_addr,
           data_valid, data_wr, data_size, data_addr, data_value,
    output mem_dout, mem_a, mem_wr, inst_ready, inst_res, data_ready, data_res
  );

  modport master (
    output clear, io_buffer_full, mem_din,
           inst_valid, inst_addr,
           data_valid, data_wr, data_size, data_addr, data_value,
    input  mem_dout, mem_a, mem_wr, inst_ready, inst_res, data_ready, data_res
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and load/store requests onto one
// byte-wide RAM/IO port, splitting each access into byte beats and returning
// a one-cycle ready pulse with the assembled/extended result.
// Ports:
//   clk_in  : system clock (rising edge)
//   rst_in  : synchronous active-high reset
//   rdy_in  : global enable; low freezes every register
//   bus     : mem_ctrl_if.slave (RAM port, fetch channel, data channel)
// Build option: define MEM_CTRL_RR_EN for round-robin arbitration,
// otherwise data has fixed priority over fetch.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  mem_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e            state_q;
  logic              own_inst_q;   // 1 = current access belongs to fetch
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [31:0]       value_q;
  logic [31:0]       buf_q;
  logic [2:0]        cnt_q;        // READ: edge index since grant; WRITE: beat on bus
  logic [2:0]        nbytes_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;
  logic              inst_ready_q;
  logic              data_ready_q;
  logic [31:0]       inst_res_q;
  logic [31:0]       data_res_q;
`ifdef MEM_CTRL_RR_EN
  logic              last_data_q;  // 1 = data won the last grant
`endif

  logic              want_inst_c;
  logic              pick_data_c;
  logic              pick_inst_c;
  logic [ADDR_W-1:0] req_addr_c;
  logic              req_write_c;
  logic [2:0]        req_n_c;
  logic              abort_c;
  logic [1:0]        rd_lane_c;
  logic [31:0]       rd_buf_d;
  logic [1:0]        wr_lane_d;
  logic [ADDR_W-1:0] wr_addr_d;

  function automatic logic is_io(input logic [ADDR_W-1:0] a);
    return a[17:16] == 2'b11;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] sz);
    case (sz[1:0])
      2'd0:    return sz[2] ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'd1:    return sz[2] ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Arbitration: a flush also masks the fetch request seen in IDLE.
  assign want_inst_c = bus.inst_valid && !bus.clear;
`ifdef MEM_CTRL_RR_EN
  assign pick_data_c = bus.data_valid && (!want_inst_c || !last_data_q);
`else
  assign pick_data_c = bus.data_valid;
`endif
  assign pick_inst_c = want_inst_c && !pick_data_c;

  assign req_addr_c  = pick_data_c ? bus.data_addr : bus.inst_addr;
  assign req_write_c = pick_data_c && bus.data_wr;
  assign req_n_c     = !pick_data_c             ? 3'd4 :
                       (bus.data_size[1:0] == 2'd0) ? 3'd1 :
                       (bus.data_size[1:0] == 2'd1) ? 3'd2 : 3'd4;

  assign abort_c = bus.clear && own_inst_q;

  // Read byte arriving this edge belongs to the address issued two edges ago.
  assign rd_lane_c = 2'(cnt_q - 3'd2);
  always_comb begin
    rd_buf_d = buf_q;
    rd_buf_d[{rd_lane_c, 3'b000} +: 8] = bus.mem_din;
  end

  assign wr_lane_d = 2'(cnt_q + 3'd1);
  assign wr_addr_d = addr_q + ADDR_W'(cnt_q + 3'd1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      own_inst_q   <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      value_q      <= '0;
      buf_q        <= '0;
      cnt_q        <= '0;
      nbytes_q     <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      inst_res_q   <= '0;
      data_res_q   <= '0;
`ifdef MEM_CTRL_RR_EN
      last_data_q  <= 1'b0;
`endif
    end else if (rdy_in) begin
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_data_c || pick_inst_c) begin
            own_inst_q <= pick_inst_c;
            addr_q     <= req_addr_c;
            size_q     <= pick_data_c ? bus.data_size : 3'b010;
            value_q    <= pick_data_c ? bus.data_value : 32'd0;
            nbytes_q   <= req_n_c;
            buf_q      <= '0;
            mem_a_q    <= req_addr_c;
            mem_dout_q <= pick_data_c ? bus.data_value[7:0] : 8'd0;
            // First beat is withheld straight away if the UART cannot take it.
            mem_wr_q   <= req_write_c && !(is_io(req_addr_c) && bus.io_buffer_full);
            cnt_q      <= req_write_c ? 3'd0 : 3'd1;
            state_q    <= req_write_c ? WRITE : READ;
`ifdef MEM_CTRL_RR_EN
            last_data_q <= pick_data_c;
`endif
          end
        end
        READ: begin
          if (abort_c) begin
            mem_a_q <= '0;
            state_q <= IDLE;
          end else begin
            if (cnt_q >= 3'd2) buf_q <= rd_buf_d;
            mem_a_q <= (cnt_q < nbytes_q) ? addr_q + ADDR_W'(cnt_q) : '0;
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == nbytes_q + 3'd1) begin
              state_q <= DONE;
              if (own_inst_q) begin
                inst_ready_q <= 1'b1;
                inst_res_q   <= rd_buf_d;
              end else begin
                data_ready_q <= 1'b1;
                data_res_q   <= extend(rd_buf_d, size_q);
              end
            end
          end
        end
        WRITE: begin
          if (mem_wr_q) begin
            if (cnt_q == nbytes_q - 3'd1) begin
              mem_wr_q     <= 1'b0;
              mem_a_q      <= '0;
              mem_dout_q   <= '0;
              data_ready_q <= 1'b1;
              data_res_q   <= '0;
              state_q      <= DONE;
            end else begin
              cnt_q      <= cnt_q + 3'd1;
              mem_a_q    <= wr_addr_d;
              mem_dout_q <= value_q[{wr_lane_d, 3'b000} +: 8];
              mem_wr_q   <= !(is_io(wr_addr_d) && bus.io_buffer_full);
            end
          end else begin
            // Stalled beat: retry on the same address once the UART drains.
            mem_wr_q <= !(is_io(mem_a_q) && bus.io_buffer_full);
          end
        end
        DONE: begin
          // The ready pulse is already on the bus; a flush here just returns to IDLE.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.inst_ready = inst_ready_q;
  assign bus.inst_res   = inst_res_q;
  assign bus.data_ready = data_ready_q;
  assign bus.data_res   = data_res_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a registered-read byte RAM.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        pk_we = 1'b0;
  logic [17:0] pk_a  = '0;
  logic [7:0]  pk_d  = '0;
  logic [7:0]  ram [0:262143];

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // RAM: data for an address appears the cycle after it is driven.
  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[17:0]];
    if (pk_we) ram[pk_a] <= pk_d;
    else if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    pk_we = 1'b1; pk_a = a; pk_d = d;
    step();
    pk_we = 1'b0;
  endtask

  task automatic do_data(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] v, output int cyc, output logic [31:0] res);
    bus.data_valid = 1'b1; bus.data_wr = wr; bus.data_size = sz;
    bus.data_addr = a; bus.data_value = v;
    cyc = -1; res = 32'hDEADBEEF;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.data_ready) begin cyc = i; res = bus.data_res; break; end
    end
    bus.data_valid = 1'b0;
    step();
  endtask

  task automatic do_inst(input logic [31:0] a, output int cyc, output logic [31:0] res);
    bus.inst_valid = 1'b1; bus.inst_addr = a;
    cyc = -1; res = 32'hDEADBEEF;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.inst_ready) begin cyc = i; res = bus.inst_res; break; end
    end
    bus.inst_valid = 1'b0;
    step();
  endtask

  task automatic contend(input logic [31:0] da, input logic [31:0] ia,
                         output int d_at, output int i_at);
    bus.data_valid = 1'b1; bus.data_wr = 1'b0; bus.data_size = 3'b100;
    bus.data_addr = da; bus.inst_valid = 1'b1; bus.inst_addr = ia;
    d_at = -1; i_at = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.data_ready) begin d_at = i; bus.data_valid = 1'b0; end
      if (bus.inst_ready) begin i_at = i; bus.inst_valid = 1'b0; end
      if (d_at > 0 && i_at > 0) break;
    end
    bus.data_valid = 1'b0; bus.inst_valid = 1'b0;
    step();
  endtask

  initial begin
    int          cyc;
    int          d_at;
    int          i_at;
    logic [31:0] res;
    logic        seen;

    rst = 1'b1; rdy = 1'b1;
    bus.clear = 1'b0; bus.io_buffer_full = 1'b0;
    bus.inst_valid = 1'b0; bus.inst_addr = '0;
    bus.data_valid = 1'b0; bus.data_wr = 1'b0; bus.data_size = '0;
    bus.data_addr = '0; bus.data_value = '0;

    // Reset state
    repeat (3) step();
    chk("rst_mem_a",      bus.mem_a,      32'd0);
    chk("rst_mem_dout",   32'(bus.mem_dout), 32'd0);
    chk("rst_mem_wr",     32'(bus.mem_wr),   32'd0);
    chk("rst_inst_ready", 32'(bus.inst_ready), 32'd0);
    chk("rst_data_ready", 32'(bus.data_ready), 32'd0);
    chk("rst_inst_res",   bus.inst_res,   32'd0);
    chk("rst_data_res",   bus.data_res,   32'd0);
    rst = 1'b0;

    poke(18'h100, 8'h78); poke(18'h101, 8'h56); poke(18'h102, 8'h34); poke(18'h103, 8'h12);
    poke(18'h200, 8'h80);
    poke(18'h300, 8'h34); poke(18'h301, 8'h12); poke(18'h302, 8'h00); poke(18'h303, 8'h90);
    poke(18'h012, 8'h00); poke(18'h013, 8'h00);

    // Loads of each size and extension
    do_data(1'b0, 3'b010, 32'h100, 32'd0, cyc, res);
    chk("lw_cyc", 32'(cyc), 32'd6);   chk("lw_res", res, 32'h12345678);
    do_data(1'b0, 3'b000, 32'h200, 32'd0, cyc, res);
    chk("lb_cyc", 32'(cyc), 32'd3);   chk("lb_res", res, 32'hFFFFFF80);
    do_data(1'b0, 3'b100, 32'h200, 32'd0, cyc, res);
    chk("lbu_res", res, 32'h00000080);
    do_data(1'b0, 3'b101, 32'h300, 32'd0, cyc, res);
    chk("lhu_cyc", 32'(cyc), 32'd4);  chk("lhu_res", res, 32'h00001234);
    do_data(1'b0, 3'b001, 32'h302, 32'd0, cyc, res);
    chk("lh_neg_res", res, 32'hFFFF9000);

    // Store half: two beats, then ready
    bus.data_valid = 1'b1; bus.data_wr = 1'b1; bus.data_size = 3'b001;
    bus.data_addr = 32'h10; bus.data_value = 32'h0000ABCD;
    step();
    chk("sh_b0_wr", 32'(bus.mem_wr), 32'd1); chk("sh_b0_a", bus.mem_a, 32'h10);
    chk("sh_b0_d", 32'(bus.mem_dout), 32'hCD);
    step();
    chk("sh_b1_wr", 32'(bus.mem_wr), 32'd1); chk("sh_b1_a", bus.mem_a, 32'h11);
    chk("sh_b1_d", 32'(bus.mem_dout), 32'hAB);
    step();
    chk("sh_end_wr", 32'(bus.mem_wr), 32'd0); chk("sh_ready", 32'(bus.data_ready), 32'd1);
    chk("sh_res", bus.data_res, 32'd0);
    bus.data_valid = 1'b0; bus.data_wr = 1'b0;
    step();
    do_data(1'b0, 3'b010, 32'h10, 32'd0, cyc, res);
    chk("sh_readback", res, 32'h0000ABCD);

    // Word fetch
    do_inst(32'h100, cyc, res);
    chk("if_cyc", 32'(cyc), 32'd6);   chk("if_res", res, 32'h12345678);

    // Contention after a fetch grant: data first in both builds
    contend(32'h200, 32'h100, d_at, i_at);
    chk("arb1_data_at", 32'(d_at), 32'd3);
    chk("arb1_inst_at", 32'(i_at), 32'd10);

    // Contention after a data grant
    do_data(1'b0, 3'b100, 32'h200, 32'd0, cyc, res);
    contend(32'h200, 32'h100, d_at, i_at);
`ifdef MEM_CTRL_RR_EN
    chk("arb2_data_at", 32'(d_at), 32'd10);
    chk("arb2_inst_at", 32'(i_at), 32'd6);
`else
    chk("arb2_data_at", 32'(d_at), 32'd3);
    chk("arb2_inst_at", 32'(i_at), 32'd10);
`endif

    // Flush during fetch: abort, then the waiting load is granted
    seen = 1'b0;
    bus.inst_valid = 1'b1; bus.inst_addr = 32'h100;
    step();
    chk("clr_a0", bus.mem_a, 32'h100);
    bus.data_valid = 1'b1; bus.data_wr = 1'b0; bus.data_size = 3'b100; bus.data_addr = 32'h200;
    step(); seen = seen | bus.inst_ready;
    step(); seen = seen | bus.inst_ready;
    chk("clr_a2", bus.mem_a, 32'h102);
    bus.clear = 1'b1; bus.inst_valid = 1'b0;
    step(); seen = seen | bus.inst_ready;
    bus.clear = 1'b0;
    chk("clr_idle_a", bus.mem_a, 32'd0);
    step(); seen = seen | bus.inst_ready;
    chk("clr_grant_a", bus.mem_a, 32'h200);
    cyc = -1; res = 32'hDEADBEEF;
    for (int i = 1; i <= 20; i++) begin
      step(); seen = seen | bus.inst_ready;
      if (bus.data_ready) begin cyc = i; res = bus.data_res; break; end
    end
    bus.data_valid = 1'b0;
    step(); seen = seen | bus.inst_ready;
    chk("clr_load_cyc", 32'(cyc), 32'd2);
    chk("clr_load_res", res, 32'h80);
    chk("clr_no_inst_ready", 32'(seen), 32'd0);

    // IO store held off while the UART buffer is full
    seen = 1'b0;
    bus.io_buffer_full = 1'b1;
    bus.data_valid = 1'b1; bus.data_wr = 1'b1; bus.data_size = 3'b000;
    bus.data_addr = 32'h30000; bus.data_value = 32'h0000005A;
    step();
    chk("io_a", bus.mem_a, 32'h30000);
    seen = seen | bus.mem_wr | bus.data_ready;
    repeat (4) begin step(); seen = seen | bus.mem_wr | bus.data_ready; end
    chk("io_stall", 32'(seen), 32'd0);
    bus.io_buffer_full = 1'b0;
    step();
    chk("io_beat_wr", 32'(bus.mem_wr), 32'd1); chk("io_beat_a", bus.mem_a, 32'h30000);
    chk("io_beat_d", 32'(bus.mem_dout), 32'h5A);
    step();
    chk("io_ready", 32'(bus.data_ready), 32'd1); chk("io_end_wr", 32'(bus.mem_wr), 32'd0);
    bus.data_valid = 1'b0; bus.data_wr = 1'b0;
    step();
    chk("io_ram", 32'(ram[18'h30000]), 32'h5A);

    // rdy_in low freezes the access for two cycles
    bus.data_valid = 1'b1; bus.data_wr = 1'b0; bus.data_size = 3'b100; bus.data_addr = 32'h200;
    step();
    rdy = 1'b0;
    step(); step();
    chk("frz_a", bus.mem_a, 32'h200);
    chk("frz_ready", 32'(bus.data_ready), 32'd0);
    rdy = 1'b1;
    cyc = -1; res = 32'hDEADBEEF;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.data_ready) begin cyc = i; res = bus.data_res; break; end
    end
    bus.data_valid = 1'b0;
    step();
    chk("frz_cyc", 32'(cyc), 32'd2);
    chk("frz_res", res, 32'h80);

    // Reset mid-access abandons it
    bus.data_valid = 1'b1; bus.data_size = 3'b010; bus.data_addr = 32'h100;
    step(); step(); step();
    rst = 1'b1; bus.data_valid = 1'b0;
    step();
    chk("rst_mid_a", bus.mem_a, 32'd0);
    chk("rst_mid_ready", 32'(bus.data_ready), 32'd0);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
